// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, tile address helpers and error flag positions.
package noc_pkg;

    localparam int NOC_ADDR_W    = 8;
    localparam int NOC_FLIT_W    = 32;
    localparam int NOC_PAYLOAD_W = NOC_FLIT_W - NOC_ADDR_W;

    typedef logic [NOC_ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t                    dest;
        logic [NOC_PAYLOAD_W-1:0] payload;
    } flit_t;

    localparam int ERR_W          = 3;
    localparam int ERR_CREDIT_OVF = 0;
    localparam int ERR_EJ_OVF     = 1;
    localparam int ERR_MISROUTE   = 2;

    function automatic addr_t make_addr(input logic [3:0] x, input logic [3:0] y);
        return {x, y};
    endfunction

    function automatic logic [3:0] addr_x(input addr_t a);
        return a[7:4];
    endfunction

    function automatic logic [3:0] addr_y(input addr_t a);
        return a[3:0];
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Parameterised synchronous circular FIFO with full/empty status and a drop indication.
module ni_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign overflow_o = push_i && !do_push;
    assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/network_interface.sv
// Router-tile network interface: credit-based single-flit injection and buffered ejection.
module network_interface
    import noc_pkg::*;
#(
    parameter int FLIT_W   = NOC_FLIT_W,
    parameter int ADDR_W   = NOC_ADDR_W,
    parameter int CREDITS  = 4,
    parameter int EJ_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    my_addr_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ADDR_W-1:0]    req_dest_i,
    input  logic [FLIT_W-ADDR_W-1:0] req_data_i,
    output logic [FLIT_W-1:0]    flit_o,
    output logic                 valid_o,
    input  logic                 credit_i,
    input  logic [FLIT_W-1:0]    flit_i,
    input  logic                 valid_i,
    output logic                 credit_o,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [FLIT_W-1:0]    resp_data_o,
    output logic [CNT_W-1:0]     tx_count_o,
    output logic [CNT_W-1:0]     rx_count_o,
    output logic [ERR_W-1:0]     err_o
);

    localparam int                CRED_W   = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    logic [CRED_W-1:0] credit_cnt_q, credit_cnt_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              valid_q;
    logic              credit_q;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic              accept;
    logic              pop;
    logic              ej_full;
    logic              ej_empty;
    logic              ej_overflow;
    logic              misroute;
    logic [FLIT_W-1:0] ej_head;

    assign req_ready_o = (credit_cnt_q != '0);
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = resp_valid_o && resp_ready_i;

    // Misroute is flagged only for flits that are actually stored; drops have their own flag.
    assign misroute = valid_i && (!ej_full || pop) &&
                      (flit_i[FLIT_W-1 -: ADDR_W] != my_addr_i);

    ni_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (valid_i),
        .data_i     (flit_i),
        .pop_i      (pop),
        .data_o     (ej_head),
        .full_o     (ej_full),
        .empty_o    (ej_empty),
        .overflow_o (ej_overflow)
    );

    always_comb begin
        credit_cnt_d = credit_cnt_q;
        flit_d       = flit_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        err_d        = err_q;

        if (accept) begin
            flit_d   = {req_dest_i, req_data_i};
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
        if (pop) rx_cnt_d = rx_cnt_q + CNT_W'(1);

        case ({accept, credit_i})
            2'b10: credit_cnt_d = credit_cnt_q - CRED_W'(1);
            2'b01: begin
                if (credit_cnt_q == CRED_MAX) err_d[ERR_CREDIT_OVF] = 1'b1;
                else                          credit_cnt_d = credit_cnt_q + CRED_W'(1);
            end
            default: ;
        endcase

        if (ej_overflow) err_d[ERR_EJ_OVF]   = 1'b1;
        if (misroute)    err_d[ERR_MISROUTE] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt_q <= CRED_MAX;
            flit_q       <= '0;
            valid_q      <= 1'b0;
            credit_q     <= 1'b0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            err_q        <= '0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            flit_q       <= flit_d;
            valid_q      <= accept;
            credit_q     <= pop;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            err_q        <= err_d;
        end
    end

    assign flit_o       = flit_q;
    assign valid_o      = valid_q;
    assign credit_o     = credit_q;
    assign resp_valid_o = !ej_empty;
    assign resp_data_o  = ej_head;
    assign tx_count_o   = tx_cnt_q;
    assign rx_count_o   = rx_cnt_q;
    assign err_o        = err_q;

endmodule
